// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states,
// opcodes, ALU operation classes, ALU control codes and mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps the controller's ALU operation class plus the
// instruction's funct fields onto the ALU's control code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Address/PC arithmetic uses add, branches compare via sub, and
    // arithmetic instructions pick their operation from funct3
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller sequencing the multicycle RV32I datapath through fetch,
// decode, execute, memory and writeback, stalling on memory ready.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [1:0] alu_op;
    logic       mem_req_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;
    logic       pc_update;
    logic       branch;

    // State register; reset forces the fetch state without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unused encodings fall back to fetch
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Per-state output decode; memory strobes wait for the ready handshake
    always_comb begin
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        alu_op        = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_raw = 1'b0;
                    default:                                  illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                adr_src       = 1'b1;
                mem_write_raw = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: begin
                mem_req_raw = 1'b0;
            end
        endcase
    end

    // Strobes are held low while reset is asserted so nothing is written
    // or fetched during an abort
    always_comb begin
        mem_req   = rst_n & mem_req_raw;
        mem_write = rst_n & mem_write_raw;
        ir_write  = rst_n & ir_write_raw;
        pc_write  = rst_n & (pc_update | (branch & zero));
        reg_write = rst_n & reg_write_raw;
        illegal   = rst_n & illegal_raw;
        state_dbg = state;
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cycle table,
// hand-written reset-abort sequence and randomized instruction stream.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state_dbg;

    int compared = 0;
    int mismatched = 0;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

    // selects packed as {adr_src, result_src, alu_src_a, alu_src_b}
    localparam logic [6:0] S_F   = 7'b0_10_00_10;
    localparam logic [6:0] S_D   = 7'b0_00_01_01;
    localparam logic [6:0] S_MA  = 7'b0_00_10_01;
    localparam logic [6:0] S_MR  = 7'b1_00_00_00;
    localparam logic [6:0] S_MWB = 7'b0_01_00_00;
    localparam logic [6:0] S_MW  = 7'b1_00_00_00;
    localparam logic [6:0] S_EXR = 7'b0_00_10_00;
    localparam logic [6:0] S_EXI = 7'b0_00_10_01;
    localparam logic [6:0] S_AWB = 7'b0_00_00_00;
    localparam logic [6:0] S_BQ  = 7'b0_00_10_00;
    localparam logic [6:0] S_JL  = 7'b0_00_01_10;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    // strobes packed as {mem_req, mem_write, reg_write, pc_write, ir_write, illegal}
    localparam logic [5:0] F_GO   = 6'b100110;
    localparam logic [5:0] F_WAIT = 6'b100000;
    localparam logic [5:0] NONE   = 6'b000000;
    localparam logic [5:0] RW     = 6'b001000;
    localparam logic [5:0] PCW    = 6'b000100;
    localparam logic [5:0] MREQ   = 6'b100000;
    localparam logic [5:0] MWR    = 6'b110000;
    localparam logic [5:0] ILL    = 6'b000001;

    typedef struct {
        logic [6:0] op;
        logic [2:0] funct3;
        logic       funct7b5;
        logic       zero;
        logic       ready;
        logic [3:0] exp_state;
        logic [5:0] exp_strobes;
        logic [6:0] exp_sel;
        logic [2:0] exp_alu;
    } vec_t;

    vec_t vectors[$];

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still reports
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic r, input logic [3:0] st,
                                input logic [5:0] strb, input logic [6:0] sel,
                                input logic [2:0] alu);
        vec_t v;
        v.op = o; v.funct3 = f3; v.funct7b5 = f7; v.zero = z; v.ready = r;
        v.exp_state = st; v.exp_strobes = strb; v.exp_sel = sel; v.exp_alu = alu;
        return v;
    endfunction

    // Drives one table row for a cycle and compares it mid-cycle
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        op = v.op; funct3 = v.funct3; funct7b5 = v.funct7b5;
        zero = v.zero; mem_ready = v.ready;
        @(negedge clk);
        tag = $sformatf("row%0d", idx);
        checkOutput({tag, ".state"}, state_dbg, v.exp_state);
        checkOutput({tag, ".strobes"},
                    {mem_req, mem_write, reg_write, pc_write, ir_write, illegal},
                    v.exp_strobes);
        checkOutput({tag, ".selects"}, {adr_src, result_src, alu_src_a, alu_src_b}, v.exp_sel);
        checkOutput({tag, ".alu_control"}, alu_control, v.exp_alu);
        @(posedge clk);
        #1;
    endtask

    // Instruction classes of the reference model
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    function automatic int num_steps(input int k);
        case (k)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit step_is_mem(input int k, input int s);
        return (s == 0) || ((k == K_LW || k == K_SW) && s == 3);
    endfunction

    function automatic logic [2:0] exp_alu_for(input int k, input int s,
                                               input logic [2:0] f3, input logic f7);
        if (k == K_BEQ && s == 2) return A_SUB;
        if ((k == K_R || k == K_I) && s == 2) begin
            case (f3)
                3'b000:  return (k == K_R && f7) ? A_SUB : A_ADD;
                3'b010:  return A_SLT;
                3'b110:  return A_OR;
                3'b111:  return A_AND;
                default: return A_ADD;
            endcase
        end
        return A_ADD;
    endfunction

    initial begin
        int s;
        int k;
        int len;
        int guard;
        logic [6:0] o;

        rst_n = 1'b0; op = T_R; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;

        // ---- reset state ----
        #12;
        checkOutput("reset.state", state_dbg, 0);
        checkOutput("reset.strobes",
                    {mem_req, mem_write, reg_write, pc_write, ir_write, illegal}, 0);
        checkOutput("reset.selects", {adr_src, result_src, alu_src_a, alu_src_b}, S_F);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed cycle table ----
        // add with a one-cycle fetch stall
        vectors.push_back(mk(T_R, 3'b000, 0, 0, 0, 0, F_WAIT, S_F, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 0, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 0, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 0, 0, 1, 6, NONE, S_EXR, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 0, 0, 1, 8, RW, S_AWB, A_ADD));
        // sub
        vectors.push_back(mk(T_R, 3'b000, 1, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 1, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 1, 0, 1, 6, NONE, S_EXR, A_SUB));
        vectors.push_back(mk(T_R, 3'b000, 1, 0, 1, 8, RW, S_AWB, A_ADD));
        // addi with funct7b5 set still adds
        vectors.push_back(mk(T_I, 3'b000, 1, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_I, 3'b000, 1, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_I, 3'b000, 1, 0, 1, 7, NONE, S_EXI, A_ADD));
        vectors.push_back(mk(T_I, 3'b000, 1, 0, 1, 8, RW, S_AWB, A_ADD));
        // lw with a three-cycle memory stall
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 1, 2, NONE, S_MA, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 0, 3, MREQ, S_MR, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 0, 3, MREQ, S_MR, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 0, 3, MREQ, S_MR, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 1, 3, MREQ, S_MR, A_ADD));
        vectors.push_back(mk(T_LW, 3'b010, 0, 0, 1, 4, RW, S_MWB, A_ADD));
        // sw with a two-cycle memory stall
        vectors.push_back(mk(T_SW, 3'b010, 0, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_SW, 3'b010, 0, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_SW, 3'b010, 0, 0, 1, 2, NONE, S_MA, A_ADD));
        vectors.push_back(mk(T_SW, 3'b010, 0, 0, 0, 5, MREQ, S_MW, A_ADD));
        vectors.push_back(mk(T_SW, 3'b010, 0, 0, 0, 5, MREQ, S_MW, A_ADD));
        vectors.push_back(mk(T_SW, 3'b010, 0, 0, 1, 5, MWR, S_MW, A_ADD));
        // beq taken then not taken
        vectors.push_back(mk(T_BEQ, 3'b000, 0, 1, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_BEQ, 3'b000, 0, 1, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_BEQ, 3'b000, 0, 1, 1, 9, PCW, S_BQ, A_SUB));
        vectors.push_back(mk(T_BEQ, 3'b000, 0, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_BEQ, 3'b000, 0, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_BEQ, 3'b000, 0, 0, 1, 9, NONE, S_BQ, A_SUB));
        // jal
        vectors.push_back(mk(T_JAL, 3'b000, 0, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(T_JAL, 3'b000, 0, 0, 1, 1, NONE, S_D, A_ADD));
        vectors.push_back(mk(T_JAL, 3'b000, 0, 0, 1, 10, PCW, S_JL, A_ADD));
        vectors.push_back(mk(T_JAL, 3'b000, 0, 0, 1, 8, RW, S_AWB, A_ADD));
        // unsupported opcode
        vectors.push_back(mk(7'b0000000, 3'b000, 0, 0, 1, 0, F_GO, S_F, A_ADD));
        vectors.push_back(mk(7'b0000000, 3'b000, 0, 0, 1, 1, ILL, S_D, A_ADD));
        vectors.push_back(mk(T_R, 3'b000, 0, 0, 0, 0, F_WAIT, S_F, A_ADD));

        foreach (vectors[i]) applyStimulus(vectors[i], i);

        // ---- reset asserted in MEMWRITE with memory ready ----
        op = T_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort.pre_state", state_dbg, 5);
        checkOutput("abort.pre_mem_write", mem_write, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.mem_write", mem_write, 0);
        checkOutput("abort.state", state_dbg, 0);
        checkOutput("abort.mem_req", mem_req, 0);
        @(posedge clk);
        #1;
        checkOutput("abort.hold_state", state_dbg, 0);
        checkOutput("abort.hold_strobes", {ir_write, pc_write, reg_write}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("recover.fetch_req", {mem_req, ir_write, pc_write}, 3'b111);
        @(posedge clk);
        #1;
        checkOutput("recover.decode", state_dbg, 1);
        @(posedge clk);
        #1;
        checkOutput("recover.memadr", state_dbg, 2);
        @(posedge clk);
        #1;
        checkOutput("recover.memwrite", state_dbg, 5);
        @(posedge clk);
        #1;
        checkOutput("recover.back_to_fetch", state_dbg, 0);

        // ---- randomized instruction stream against the step model ----
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                K_LW:    o = T_LW;
                K_SW:    o = T_SW;
                K_R:     o = T_R;
                K_I:     o = T_I;
                K_BEQ:   o = T_BEQ;
                K_JAL:   o = T_JAL;
                default: begin
                    o = 7'($urandom);
                    while (o == T_LW || o == T_SW || o == T_R || o == T_I ||
                           o == T_BEQ || o == T_JAL)
                        o = 7'($urandom);
                end
            endcase
            op = o;
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            zero = 1'($urandom);
            len = num_steps(k);
            s = 0;
            guard = 0;
            while (s < len) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (s == 0) checkOutput("rand.start_state", state_dbg, 0);
                checkOutput("rand.mem_req", mem_req, int'(step_is_mem(k, s)));
                checkOutput("rand.ir_write", ir_write, int'(s == 0 && mem_ready));
                checkOutput("rand.mem_write", mem_write, int'(k == K_SW && s == 3 && mem_ready));
                checkOutput("rand.reg_write", reg_write,
                            int'(s == len - 1 && (k == K_LW || k == K_R || k == K_I || k == K_JAL)));
                checkOutput("rand.pc_write", pc_write,
                            int'((s == 0 && mem_ready) || (k == K_BEQ && s == 2 && zero) ||
                                 (k == K_JAL && s == 2)));
                checkOutput("rand.illegal", illegal, int'(k == K_ILL && s == 1));
                checkOutput("rand.alu_control", alu_control, exp_alu_for(k, s, funct3, funct7b5));
                if (!(step_is_mem(k, s) && !mem_ready)) s++;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 200) begin
                    checkOutput("rand.cycle_budget", guard, 200);
                    s = len;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
